fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined ARM processor. It owns the program counter, drives the address port of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register consumed by decode. It applies hazard-unit stalls and flushes and branch redirects from execute, and keeps a saturating count of words delivered to decode.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and registers the returned word into the IF/ID register for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus8_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic        ifid_load;

  // Branch redirect wins over a fetch stall; the target is always word-aligned.
  always_comb begin
    pc_next = pc_f + 32'd4;
    if (br_taken) begin
      pc_next = {br_target[31:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_f;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  assign imem_addr = pc_f;
  assign ifid_load = !flush_d && !stall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d <= 32'h0;
      pc_d    <= 32'h0;
      valid_d <= 1'b0;
    end else if (flush_d) begin
      instr_d <= 32'h0;
      pc_d    <= 32'h0;
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      instr_d <= imem_instr;
      pc_d    <= pc_f;
      valid_d <= 1'b1;
    end
  end

  assign pc_plus8_d = pc_d + 32'd8;

  // Counts words handed to decode; sticks at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (ifid_load && (fetch_count != {CNT_W{1'b1}})) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a queue-free
// architectural model of the PC and the IF/ID register.
module tb_fetch_stage;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             stall_f, stall_d, flush_d, br_taken;
  logic [31:0]      br_target;
  logic [31:0]      imem_addr, imem_instr;
  logic [31:0]      instr_d, pc_d, pc_plus8_d;
  logic             valid_d;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] mem [64];

  int total;
  int passed;

  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid;
  int          m_cnt;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus8_d (pc_plus8_d),
    .valid_d    (valid_d),
    .fetch_count(fetch_count)
  );

  assign imem_instr = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all();
    chk("imem_addr",   imem_addr,             m_pc);
    chk("instr_d",     instr_d,               m_instr);
    chk("pc_d",        pc_d,                  m_pcd);
    chk("pc_plus8_d",  pc_plus8_d,            m_pcd + 32'd8);
    chk("valid_d",     {31'b0, valid_d},      {31'b0, m_valid});
    chk("fetch_count", {29'b0, fetch_count},  m_cnt);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic sf, input logic sd, input logic fd,
                      input logic bt, input logic [31:0] tgt);
    logic [31:0] word;
    stall_f = sf; stall_d = sd; flush_d = fd; br_taken = bt; br_target = tgt;
    @(posedge clk);
    word = mem[(m_pc / 4) % 64];
    if (fd) begin
      m_instr = 32'h0; m_pcd = 32'h0; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = word; m_pcd = m_pc; m_valid = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (bt)       m_pc = tgt & 32'hFFFF_FFFC;
    else if (!sf) m_pc = m_pc + 32'd4;
    #1;
    check_all();
    @(negedge clk);
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    stall_f = 0; stall_d = 0; flush_d = 0; br_taken = 0; br_target = 0;
    rst = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Free-running after reset.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h0);
    chk("free_addr",  imem_addr,            32'h10);
    chk("free_instr", instr_d,              32'hA000_0003);
    chk("free_pc8",   pc_plus8_d,           32'h14);
    chk("free_count", {29'b0, fetch_count}, 32'd4);

    // Paired stall holds both PC and IF/ID.
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    chk("stall_addr",  imem_addr,            32'h10);
    chk("stall_instr", instr_d,              32'hA000_0003);
    chk("stall_count", {29'b0, fetch_count}, 32'd4);
    step(0, 0, 0, 0, 32'h0);

    // Branch overrides stall_f and drops the low target bits.
    step(1, 0, 0, 1, 32'h0000_0033);
    chk("br_addr", imem_addr, 32'h30);
    step(0, 0, 0, 0, 32'h0);
    chk("br_instr", instr_d, 32'hA000_000C);
    chk("br_pcd",   pc_d,    32'h30);

    // Flush beats stall_d and does not count.
    step(0, 1, 1, 0, 32'h0);
    chk("flush_valid", {31'b0, valid_d}, 32'h0);
    chk("flush_instr", instr_d,          32'h0);

    // Asynchronous reset in the middle of a cycle.
    step(0, 0, 0, 1, 32'h0000_001C);
    chk("pre_rst_addr", imem_addr, 32'h1C);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 32'h0);
    chk("post_rst_instr", instr_d, 32'hA000_0000);

    // Counter saturation.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 32'h0);
    chk("sat_count", {29'b0, fetch_count}, 32'd7);

    // PC wraps modulo 2^32.
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pcd",  pc_d,      32'hFFFF_FFFC);

    // Randomized control mix, with occasional reset to restart the counter.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
